// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU.
//   OP_W    - opcode width
//   op_e    - opcode enumeration (values match the op input encoding)
//   state_e - control FSM states
package seq_alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_INC  = 4'd2,
    OP_DEC  = 4'd3,
    OP_MUL  = 4'd4,
    OP_DIV  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_NAND = 4'd9,
    OP_NOR  = 4'd10,
    OP_XNOR = 4'd11,
    OP_SHL  = 4'd12,
    OP_SHR  = 4'd13,
    OP_ROTR = 4'd14,
    OP_ROTL = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative unsigned multiply (shift-add) / divide (restoring).
// Runs exactly WIDTH steps after a start pulse; done is high during the cycle
// whose closing edge performs the last step, and result then carries the
// post-step value so the caller can register it on that same edge.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any operation)
//   start      : load operands and begin
//   is_div     : 1 = divide, 0 = multiply (sampled with start)
//   a, b       : operands (multiplier/multiplicand or dividend/divisor)
//   done       : last step in progress
//   result     : product, or {remainder, quotient}
module seq_alu_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             r_busy;
  logic             r_is_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;   // mul: partial product high half; div: remainder
  logic [WIDTH-1:0] r_lo;   // mul: multiplier shifting out;   div: dividend -> quotient
  logic [WIDTH-1:0] r_opb;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_fit;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_next;

  always_comb begin
    // Add multiplicand when the current multiplier bit is set, then shift the
    // whole {carry, hi, lo} right by one.
    w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_mul_next = {w_mul_sum, r_lo[WIDTH-1:1]};
    // Shift the next dividend bit into the remainder; subtract if it fits.
    // When it does not fit the top bit is necessarily 0, so WIDTH bits suffice.
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_fit   = (w_div_shift >= {1'b0, r_opb});
    w_div_rem   = w_div_fit ? (w_div_shift[WIDTH-1:0] - r_opb) : w_div_shift[WIDTH-1:0];
    w_next      = r_is_div ? {w_div_rem, r_lo[WIDTH-2:0], w_div_fit} : w_mul_next;
  end

  assign done   = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign result = w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_is_div <= is_div;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= a;
      r_opb    <= b;
    end else if (r_busy) begin
      {r_hi, r_lo} <= w_next;
      r_cnt        <= r_cnt + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshakes on request and result.
// Single-cycle ops complete one cycle after accept; mul and div (b != 0) take
// WIDTH extra cycles in the iterative sub-unit. Results are held until taken.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (ready only in IDLE)
//   a, b, op            : unsigned operands and opcode
//   out_valid/out_ready : result handshake
//   y                   : 2*WIDTH result
//   carry, zero, ovf, dz: carry/borrow, zero, signed overflow, divide-by-zero
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OP_W-1:0]    op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               carry,
  output logic               zero,
  output logic               ovf,
  output logic               dz
);

  state_e             r_state;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_y;
  logic               r_carry, r_zero, r_ovf, r_dz;

  op_e                w_op;
  logic               w_sub;
  logic [WIDTH-1:0]   w_rhs;
  logic [WIDTH:0]     w_sum;
  logic               w_arith_ovf;
  logic [WIDTH-1:0]   w_hi, w_lo;
  logic               w_c, w_o, w_d;
  logic [2*WIDTH-1:0] w_y;
  logic               w_md_start, w_md_done;
  logic [2*WIDTH-1:0] w_md_result;

  assign w_op = op_e'(op);

  // Shared adder for add/sub/inc/dec; the extended top bit is carry or borrow.
  always_comb begin
    w_sub = (w_op == OP_SUB) || (w_op == OP_DEC);
    w_rhs = ((w_op == OP_INC) || (w_op == OP_DEC)) ? WIDTH'(1) : b;
    w_sum = w_sub ? ({1'b0, a} - {1'b0, w_rhs}) : ({1'b0, a} + {1'b0, w_rhs});
    w_arith_ovf = ((a[WIDTH-1] ^ w_rhs[WIDTH-1]) == w_sub) &&
                  (w_sum[WIDTH-1] != a[WIDTH-1]);
  end

  always_comb begin
    w_hi = '0;
    w_lo = '0;
    w_c  = 1'b0;
    w_o  = 1'b0;
    w_d  = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        w_lo = w_sum[WIDTH-1:0];
        w_c  = w_sum[WIDTH];
        w_o  = w_arith_ovf;
      end
      // Only reached with b == 0; nonzero divisors go to the iterative unit.
      OP_DIV: begin
        w_hi = a;
        w_lo = '1;
        w_d  = 1'b1;
      end
      OP_AND:  w_lo = a & b;
      OP_OR:   w_lo = a | b;
      OP_XOR:  w_lo = a ^ b;
      OP_NAND: w_lo = ~(a & b);
      OP_NOR:  w_lo = ~(a | b);
      OP_XNOR: w_lo = ~(a ^ b);
      OP_SHL: begin
        w_lo = {a[WIDTH-2:0], 1'b0};
        w_c  = a[WIDTH-1];
      end
      OP_SHR: begin
        w_lo = {1'b0, a[WIDTH-1:1]};
        w_c  = a[0];
      end
      OP_ROTR: w_lo = {a[0], a[WIDTH-1:1]};
      OP_ROTL: w_lo = {a[WIDTH-2:0], a[WIDTH-1]};
      default: ;
    endcase
    w_y = {w_hi, w_lo};
  end

  assign w_md_start = (r_state == ST_IDLE) && in_valid &&
                      ((w_op == OP_MUL) || ((w_op == OP_DIV) && (b != '0)));

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_md_start),
    .is_div (w_op == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (w_md_done),
    .result (w_md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (w_op == OP_MUL) begin
              r_state <= ST_MUL;
            end else if (w_md_start) begin
              r_state <= ST_DIV;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_y         <= w_y;
              r_carry     <= w_c;
              r_zero      <= ~|w_y;
              r_ovf       <= w_o;
              r_dz        <= w_d;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_md_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_y         <= w_md_result;
            r_carry     <= 1'b0;
            r_zero      <= ~|w_md_result;
            r_ovf       <= (r_state == ST_MUL) && (|w_md_result[2*WIDTH-1:WIDTH]);
            r_dz        <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign dz        = r_dz;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven bench for seq_alu (WIDTH=8) with an expected-result
// queue filled on request and drained when a result is handed over.
module tb_seq_alu;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [3:0]     op = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] y;
  logic           carry, zero, ovf, dz;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf),
    .dz        (dz)
  );

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
    logic        c, z, o, d;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] y;
    logic        c, z, o, d;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, " y"},     32'(y),     32'(e.y));
    check({tag, " carry"}, 32'(carry), 32'(e.c));
    check({tag, " zero"},  32'(zero),  32'(e.z));
    check({tag, " ovf"},   32'(ovf),   32'(e.o));
    check({tag, " dz"},    32'(dz),    32'(e.d));
  endtask

  // Drive one request from a negedge, measure accept-to-out_valid latency in
  // cycles, compare the result and (with out_ready high) the handover.
  task automatic run_vec(input vec_t v, input string tag);
    int   n;
    logic busy_ready;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    op = v.op;
    a  = v.a;
    b  = v.b;
    sb.push_back('{v.y, v.c, v.z, v.o, v.d});
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    busy_ready = 1'b0;
    while (!out_valid && n < 40) begin
      busy_ready |= in_ready;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(v.lat));
    if (v.lat > 1) check({tag, " in_ready_while_busy"}, 32'(busy_ready), 32'd0);
    compare_out(tag);
    @(negedge clk);
    check({tag, " out_valid_dropped"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vt[23];

  initial begin
    vt[0]  = '{4'd0,  8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vt[1]  = '{4'd0,  8'h7F, 8'h01, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vt[2]  = '{4'd1,  8'h05, 8'h07, 16'h00FE, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vt[3]  = '{4'd2,  8'hFF, 8'h33, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vt[4]  = '{4'd3,  8'h00, 8'h00, 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vt[5]  = '{4'd3,  8'h80, 8'h00, 16'h007F, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vt[6]  = '{4'd4,  8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b1, 1'b0, 9};
    vt[7]  = '{4'd4,  8'h0C, 8'h0B, 16'h0084, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    vt[8]  = '{4'd5,  8'd100, 8'd7, 16'h020E, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    vt[9]  = '{4'd5,  8'h12, 8'h00, 16'h12FF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vt[10] = '{4'd6,  8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vt[11] = '{4'd7,  8'hF0, 8'h0F, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vt[12] = '{4'd8,  8'hAA, 8'hAA, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vt[13] = '{4'd9,  8'hF0, 8'h3C, 16'h00CF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vt[14] = '{4'd10, 8'hF0, 8'h0F, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vt[15] = '{4'd11, 8'hA5, 8'h0F, 16'h0055, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vt[16] = '{4'd12, 8'h81, 8'h00, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vt[17] = '{4'd13, 8'h81, 8'h00, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vt[18] = '{4'd14, 8'h01, 8'h00, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vt[19] = '{4'd15, 8'h81, 8'h00, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vt[20] = '{4'd4,  8'h00, 8'h55, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 9};
    vt[21] = '{4'd5,  8'h07, 8'h10, 16'h0700, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    vt[22] = '{4'd5,  8'hFF, 8'h01, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 9};

    // Reset state while rst_n is held low.
    #2;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset y",         32'(y),         32'd0);
    check("reset flags",     32'({carry, zero, ovf, dz}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First vector is driven straight away, so it is accepted on the first
    // rising edge with reset released.
    for (int i = 0; i < 23; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Held result under consumer backpressure.
    begin
      int   n;
      logic stable;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      op = 4'd1;
      a  = 8'h80;
      b  = 8'h01;
      sb.push_back('{16'h007F, 1'b0, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
      in_valid = 1'b0;
      stable = 1'b1;
      for (n = 0; n < 5; n++) begin
        if (!(out_valid && y == 16'h007F && ovf && !carry && !zero && !dz && !in_ready))
          stable = 1'b0;
        if (n < 4) @(negedge clk);
      end
      check("stall outputs_stable", 32'(stable), 32'd1);
      compare_out("stall");
      out_ready = 1'b1;
      @(negedge clk);
      check("stall out_valid_dropped", 32'(out_valid), 32'd0);
      check("stall back_to_idle",      32'(in_ready),  32'd1);
    end

    // Reset in the middle of a multiply aborts it.
    begin
      logic seen;
      in_valid = 1'b1;
      op = 4'd4;
      a  = 8'hFF;
      b  = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midmul in_ready_low", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort y",         32'(y),         32'd0);
      check("abort flags",     32'({carry, zero, ovf, dz}), 32'd0);
      check("abort in_ready",  32'(in_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        seen |= out_valid;
      end
      check("abort no_out_valid", 32'(seen), 32'd0);
      run_vec('{4'd15, 8'h81, 8'h00, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1}, "post_reset_rotl");
    end

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width (legal range 4..32).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 in_valid  input  1  SHALL flag a valid operation request.
REQ-005 in_ready  output  1  SHALL flag that a request is accepted this cycle.
REQ-006 a, b  input  WIDTH each  SHALL be the unsigned operands.
REQ-007 op  input  4  SHALL be the opcode: 0 add, 1 sub, 2 inc a, 3 dec a, 4 mul, 5 div, 6 and, 7 or, 8 xor, 9 nand, 10 nor, 11 xnor, 12 shl, 13 shr, 14 rotr, 15 rotl.
REQ-008 out_valid  output  1  SHALL flag a valid result.
REQ-009 out_ready  input  1  SHALL flag consumer acceptance of the result.
REQ-010 y  output  2*WIDTH  SHALL be the result.
REQ-011 carry, zero, ovf, dz  output  1 each  SHALL be the carry/borrow, zero, signed-overflow and divide-by-zero flags.

Function
REQ-012 FSM states: IDLE, MUL, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-013 Handshake: request accepted when in_valid && in_ready; a, b, op captured on that edge.
REQ-014 Single-cycle ops (all except 4, 5): IDLE->DONE on accept; out_valid high on the next cycle (latency 1).
REQ-015 op 4: IDLE->MUL; shift-add, exactly WIDTH cycles in MUL, then DONE; out_valid rises WIDTH+1 cycles after accept; y = full 2*WIDTH product.
REQ-016 op 5, b != 0: IDLE->DIV; restoring division, WIDTH cycles, then DONE; y = {remainder, quotient}, each WIDTH bits.
REQ-017 op 5, b == 0: IDLE->DONE with latency 1; y = {a, all-ones}; dz = 1.
REQ-018 DONE: out_valid = 1; y and flags SHALL remain stable until out_ready; on out_valid && out_ready -> IDLE, out_valid low next cycle.
REQ-019 Single-cycle results: upper WIDTH bits of y zero except op 5; add/sub/inc/dec results mod 2^WIDTH.
REQ-020 carry: add/inc = carry out; sub/dec = borrow (a<b, or a==0 for dec); shl = a[WIDTH-1]; shr = a[0]; otherwise 0.
REQ-021 ovf: add/sub/inc/dec = two's-complement overflow of the WIDTH-bit result; mul = product upper half nonzero; otherwise 0.
REQ-022 zero = 1 iff all 2*WIDTH bits of y are 0; dz = 0 for all but REQ-017.
REQ-023 rotr = {a[0], a[WIDTH-1:1]}; rotl = {a[WIDTH-2:0], a[WIDTH-1]}; shl/shr fill with 0.
REQ-024 in_valid with in_ready low SHALL have no effect; the requester holds the request.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, out_valid 0, y 0, all flags 0, internal operand/accumulator registers 0; in_ready reads 1.
REQ-026 Reset during MUL/DIV/DONE SHALL abort the operation; no out_valid for it after release.
REQ-027 First request is accepted on the first rising clk edge with rst_n high.

Structure
REQ-028 Package seq_alu_pkg SHALL hold the opcode enumeration, FSM state enumeration and the opcode-width constant (4).
REQ-029 Iterative mul/div datapath SHALL be sub-module seq_alu_muldiv (start, is_div, a, b -> done, result), WIDTH-parametrised; top holds FSM, single-cycle ops, flags and output registers.

Verification (WIDTH=8)
REQ-030 op 0, a=0xFF, b=0x01, out_ready=1 -> out_valid 1 cycle after accept, y=0x0000, carry=1, zero=1, ovf=0.
REQ-031 op 4, a=0xFF, b=0xFF -> out_valid exactly 9 cycles after accept, y=0xFE01, ovf=1; in_ready=0 meanwhile.
REQ-032 op 5, a=100, b=7 -> y=0x020E (rem 2, quot 14) after 9 cycles; op 5, a=0x12, b=0 -> y=0x12FF, dz=1, latency 1.
REQ-033 op 1, a=0x80, b=0x01, out_ready held 0 for 5 cycles -> y=0x007F, ovf=1, carry=0, outputs stable 5 cycles, IDLE 1 cycle after out_ready.
REQ-034 op 4 accepted, rst_n pulsed low mid-MUL -> all outputs 0 immediately, no out_valid afterwards, next op 15 a=0x81 -> y=0x0003.
